execute_unit: RTL

- Execute stage of the SimpleRISC pipeline, directly downstream of operand fetch.
- Consumes op1/op2/immx/branchTarget plus decoded control and selects operand B. Computes the ALU result, maintains the E/GT flags register and resolves branches.
- Single-cycle ops for all but MUL/DIV/MOD, which run through an iterative multi-cycle unit under a valid/ready handshake.
- Results go to the memory-access/writeback stage as a one-cycle out_valid pulse.

---
 rtl/simplerisc_pkg.sv | 45 ++++
 rtl/execute_unit_muldiv_iter.sv | 126 ++++++++++++
 rtl/execute_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/simplerisc_pkg.sv
// ---------------------------------------------------------------------------
// simplerisc_pkg
// Shared definitions for the SimpleRISC execute stage.
//   - ALU operation codes carried on alu_op
//   - execute-stage FSM state type
//   - operation selector for the iterative multiply/divide unit
//   - default datapath and opcode widths
// ---------------------------------------------------------------------------
package simplerisc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;
    localparam logic [3:0] OP_NOP = 4'd13;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } exec_state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_MOD
    } md_op_t;

    // True for the operations that go through the iterative unit.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/execute_unit_muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Iterative multiply / divide / modulo, one step per clock, DATA_W steps.
// Ports:
//   clk, Reset  : clock and synchronous active-high reset
//   start       : load operands and begin (only honoured when idle)
//   op          : MD_MUL, MD_DIV or MD_MOD
//   a, b        : operands (two's complement)
//   done        : high during the cycle whose rising edge performs the last
//                 step; result is valid combinationally in that cycle
//   result      : final value (low DATA_W bits of product, quotient or
//                 remainder with sign fix-up applied)
// ---------------------------------------------------------------------------
module muldiv_iter
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  md_op_t            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // acc : running product (MUL) or partial remainder (DIV/MOD)
    // wa  : multiplier shifting right (MUL) or dividend/quotient shifting left
    // wb  : multiplicand shifting left (MUL) or divisor magnitude
    logic [CNT_W-1:0]  count;
    md_op_t            op_q;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] wa, wa_nxt;
    logic [DATA_W-1:0] wb, wb_nxt;
    logic [DATA_W-1:0] a_q;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              busy;

    assign busy = (count != '0);
    assign done = (count == CNT_W'(1));

    // One iteration step. The product's low bits do not depend on operand
    // signs, so MUL works on raw two's complement values. Division runs a
    // restoring step on magnitudes; the remainder never exceeds the divisor
    // magnitude, so the shifted remainder always fits in DATA_W bits except
    // for divide-by-zero, whose result is overridden below.
    always_comb begin
        acc_nxt = acc;
        wa_nxt  = wa;
        wb_nxt  = wb;
        shifted = '0;
        trial   = '0;
        if (op_q == MD_MUL) begin
            acc_nxt = acc + (wa[0] ? wb : '0);
            wa_nxt  = wa >> 1;
            wb_nxt  = wb << 1;
        end else begin
            shifted = {acc, wa[DATA_W-1]};
            trial   = shifted - {1'b0, wb};
            if (!trial[DATA_W]) begin
                acc_nxt = trial[DATA_W-1:0];
                wa_nxt  = {wa[DATA_W-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[DATA_W-1:0];
                wa_nxt  = {wa[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Final value is formed from the step outputs so that the result is
    // ready in the same cycle as the last step, letting the parent register
    // it at that edge. Quotient is negative when operand signs differ;
    // remainder follows the dividend's sign.
    always_comb begin
        case (op_q)
            MD_MUL:  result = acc_nxt;
            MD_DIV:  result = div_zero ? '1  : (neg_q ? -wa_nxt  : wa_nxt);
            default: result = div_zero ? a_q : (neg_r ? -acc_nxt : acc_nxt);
        endcase
    end

    // Operand load on start, then one step per cycle until the counter
    // runs out. Reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (Reset) begin
            count    <= '0;
            op_q     <= MD_MUL;
            acc      <= '0;
            wa       <= '0;
            wb       <= '0;
            a_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start && !busy) begin
            count    <= CNT_W'(DATA_W);
            op_q     <= op;
            acc      <= '0;
            a_q      <= a;
            neg_q    <= a[DATA_W-1] ^ b[DATA_W-1];
            neg_r    <= a[DATA_W-1];
            div_zero <= (b == '0);
            if (op == MD_MUL) begin
                wa <= b;
                wb <= a;
            end else begin
                wa <= a[DATA_W-1] ? -a : a;
                wb <= b[DATA_W-1] ? -b : b;
            end
        end else if (busy) begin
            count <= count - CNT_W'(1);
            acc   <= acc_nxt;
            wa    <= wa_nxt;
            wb    <= wb_nxt;
        end
    end

endmodule

// File: rtl/execute_unit.sv
// ---------------------------------------------------------------------------
// execute_unit
// Execute stage of the SimpleRISC pipeline. Selects operand B, computes the
// ALU result, keeps the E/GT flags and resolves branches. MUL/DIV/MOD are
// handed to muldiv_iter and take DATA_W cycles; everything else completes
// at the acceptance edge.
// Ports:
//   clk, Reset          : clock, synchronous active-high reset
//   in_valid / in_ready : upstream handshake, accept when both high
//   alu_op              : operation code (simplerisc_pkg OP_*)
//   isImmediate         : operand B is immx instead of op2
//   op1, op2, immx      : operand A, register operand B, immediate
//   branchTarget        : PC-relative branch target
//   isBeq/isBgt/isUBranch/isRet : branch controls
//   out_valid           : one-cycle pulse per completed instruction
//   aluResult           : result value
//   isBranchTaken, branchPC : branch redirect, qualified by out_valid
//   flag_E, flag_GT     : flags written by CMP
// ---------------------------------------------------------------------------
module execute_unit
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   alu_op,
    input  logic              isImmediate,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] immx,
    input  logic [DATA_W-1:0] branchTarget,
    input  logic              isBeq,
    input  logic              isBgt,
    input  logic              isUBranch,
    input  logic              isRet,
    output logic              out_valid,
    output logic [DATA_W-1:0] aluResult,
    output logic              isBranchTaken,
    output logic [DATA_W-1:0] branchPC,
    output logic              flag_E,
    output logic              flag_GT
);

    exec_state_t       state, state_nxt;
    logic [3:0]        op_code;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic              multi;
    logic              accept;
    logic              md_start;
    logic              md_done;
    md_op_t            md_op;
    logic [DATA_W-1:0] md_result;
    logic [DATA_W-1:0] single_result;
    logic              taken_now;
    logic [DATA_W-1:0] target_now;
    logic              pend_taken;
    logic [DATA_W-1:0] pend_pc;

    assign op_code  = alu_op[3:0];
    assign op_a     = op1;
    assign op_b     = isImmediate ? immx : op2;
    assign shamt    = op_b[4:0];
    assign multi    = is_multicycle(op_code);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && multi;
    assign md_op    = (op_code == OP_MUL) ? MD_MUL :
                      (op_code == OP_DIV) ? MD_DIV : MD_MOD;

    // Branch decision uses the flags as they stand before this edge, so a
    // CMP accepted one edge earlier is already visible here.
    assign taken_now  = isUBranch | (isBeq & flag_E) | (isBgt & flag_GT);
    assign target_now = isRet ? op1 : branchTarget;

    muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk    (clk),
        .Reset  (Reset),
        .start  (md_start),
        .op     (md_op),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle ALU. CMP, NOP and any unassigned code produce zero.
    always_comb begin
        single_result = '0;
        case (op_code)
            OP_ADD:  single_result = op_a + op_b;
            OP_SUB:  single_result = op_a - op_b;
            OP_AND:  single_result = op_a & op_b;
            OP_OR:   single_result = op_a | op_b;
            OP_NOT:  single_result = ~op_b;
            OP_MOV:  single_result = op_b;
            OP_LSL:  single_result = op_a << shamt;
            OP_LSR:  single_result = op_a >> shamt;
            OP_ASR:  single_result = $signed(op_a) >>> shamt;
            default: single_result = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and ready. Instructions are only taken in IDLE; the FSM
    // leaves BUSY at the edge that performs the final iteration, so a new
    // instruction can be accepted while out_valid pulses for the old one.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && multi) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result, branch and flag registers. Single-cycle ops publish at the
    // acceptance edge. Multi-cycle ops keep their branch decision in the
    // pending registers so visible outputs do not change until completion.
    always_ff @(posedge clk) begin
        if (Reset) begin
            out_valid     <= 1'b0;
            aluResult     <= '0;
            isBranchTaken <= 1'b0;
            branchPC      <= '0;
            flag_E        <= 1'b0;
            flag_GT       <= 1'b0;
            pend_taken    <= 1'b0;
            pend_pc       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == ST_BUSY && md_done) begin
                out_valid     <= 1'b1;
                aluResult     <= md_result;
                isBranchTaken <= pend_taken;
                branchPC      <= pend_pc;
            end
            if (accept) begin
                if (multi) begin
                    pend_taken <= taken_now;
                    pend_pc    <= target_now;
                end else begin
                    out_valid     <= 1'b1;
                    aluResult     <= single_result;
                    isBranchTaken <= taken_now;
                    branchPC      <= target_now;
                    if (op_code == OP_CMP) begin
                        flag_E  <= (op_a == op_b);
                        flag_GT <= ($signed(op_a) > $signed(op_b));
                    end
                end
            end
        end
    end

endmodule
